krr_round_iter: RTL
===================

Name: krr_round_iter

Overview:
- Iterative 64-bit key-mixing round engine, one round per clock, using the 16-bit-controlled shuffle network as its per-round permutation.
- Sits directly upstream of the KRR output path.
- Accepts a data/key pair over a valid/ready handshake, runs ROUNDS rounds, then presents the result over a valid/ready handshake.
- Serves the KRR execute-unit path for multi-cycle key-ring ops.

Parameters:
- ROUNDS, 4, number of rounds per block (1..16).
- CNTW, 4, round-counter width; must satisfy 2^CNTW >= ROUNDS.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous flush; cancels any block in flight.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine can accept a block.
- in_data  in  64  plaintext block.
- in_key  in  64  block key.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  64  result block.
- busy  out  1  engine not IDLE.

Behaviour:
- Reset (reset low, asynchronous) forces:
  - state=IDLE, round counter=0, data and key registers=0.
  - outputs: in_ready=1, out_valid=0, out_data=0, busy=0.
- Reset asserted mid-block discards the block; no output is produced for it.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid && in_ready: latch x=in_data and k=in_key, cnt=0, go to RUN.
  - RUN: in_ready=0, busy=1. Each clock: x <= SHUF(x ^ rk, rk[15:0]), where rk = k rotated left by 16*cnt (mod 64); cnt <= cnt+1. When cnt==ROUNDS-1, that round's result is written and the state goes to DONE.
  - DONE: out_valid=1, out_data=x, held stable until out_ready. On out_valid && out_ready, go to IDLE.
- No same-cycle re-accept: the earliest next accept is the cycle after the output handshake.
- Latency: accept at clock edge E; out_valid rises after edge E+ROUNDS. With ROUNDS=1, out_valid is high one cycle after accept.
- Throughput: one block per ROUNDS+2 cycles when out_ready is held high.
- abort: in any state, next state=IDLE, out_valid=0, cnt=0. abort has priority over an in/out handshake in the same cycle; that handshake does not take effect.
- out_data reads 0 outside DONE. The x register is not exposed.
- SHUF(v, s) is purely combinational and applied in this order:
  1. s[14]: swap the 32-bit halves.
  2. s[12]: swap the 16-bit halves within [31:0]. s[13]: same within [63:32].
  3. s[8..11]: swap the bytes within 16-bit lane 0..3.
  4. s[0..7]: swap the nibbles within byte 0..7.
  5. s[15]: out = {v[31:16], v[47:32], v[63:48], v[15:0]}.
- All arithmetic is 64-bit XOR or rotate; no carries. The rotate amount is 16*cnt mod 64.
- in_valid seen while not IDLE is ignored; the upstream holds it.

Decomposition:
- Shared package krr_pkg holds:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Named bit-index constants for the 16 shuffle control bits.
- One natural sub-module: krr_shuf_net, the combinational SHUF function. It is instantiated once on the round datapath.

Test Plan:
- ROUNDS=4, key=0, data=0x0123456789ABCDEF, out_ready=1:
  - out_data=0x0123456789ABCDEF.
  - out_valid exactly 4 cycles after accept; busy high for 5 cycles.
- ROUNDS=1, key=0x0000000000004000, data=0x0123456789ABCDEF -> out_data=0x89AB8DEF01234567.
- ROUNDS=1, key=0x0000000000000001, data=0 -> out_data=0x0000000000000010.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after DONE, with in_valid held high.
  - Response: out_data is stable and in_ready=0 throughout; the second block is accepted only the cycle after out_ready=1.
- abort asserted in the 2nd RUN cycle with ROUNDS=4 -> next cycle IDLE, in_ready=1, no out_valid pulse ever.
- reset driven low mid-RUN, asynchronously between edges -> outputs go to reset values immediately. After release, a fresh block with key=0 returns its data unchanged.

Source files
------------

// File: rtl/krr_pkg.sv
// Shared definitions for the KRR round engine: FSM encoding, shuffle control
// bit positions and the per-round key schedule.
package krr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } krr_state_e;

  // Shuffle control word layout: [7:0] nibble swaps, [11:8] byte swaps,
  // [13:12] 16-bit half swaps, [14] 32-bit half swap, [15] lane mix.
  localparam int SHUF_NIB_BASE  = 0;
  localparam int SHUF_BYTE_BASE = 8;
  localparam int SHUF_HALF16_LO = 12;
  localparam int SHUF_HALF16_HI = 13;
  localparam int SHUF_HALF32    = 14;
  localparam int SHUF_LANE_MIX  = 15;

  function automatic logic [63:0] krr_round_key(input logic [63:0] k, input logic [1:0] q);
    logic [63:0] rk;
    case (q)
      2'd0:    rk = k;
      2'd1:    rk = {k[47:0], k[63:48]};
      2'd2:    rk = {k[31:0], k[63:32]};
      default: rk = {k[15:0], k[63:16]};
    endcase
    return rk;
  endfunction

endpackage

// File: rtl/krr_round_iter_if.sv
// Block-in / result-out handshake bundle for the KRR round engine.
interface krr_round_iter_if;

  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/krr_shuf_net.sv
// Combinational 16-bit-controlled shuffle network used as the round permutation.
module krr_shuf_net
  import krr_pkg::*;
(
  input  logic [63:0] i_v,
  input  logic [15:0] i_s,
  output logic [63:0] o_v
);

  logic [63:0] w_s1;
  logic [63:0] w_s2;
  logic [63:0] w_s3;
  logic [63:0] w_s4;

  // Stages run coarse to fine, then the final lane mix swaps lanes 1 and 3.
  always_comb begin
    w_s1 = i_s[SHUF_HALF32] ? {i_v[31:0], i_v[63:32]} : i_v;

    w_s2[31:0]  = i_s[SHUF_HALF16_LO] ? {w_s1[15:0], w_s1[31:16]} : w_s1[31:0];
    w_s2[63:32] = i_s[SHUF_HALF16_HI] ? {w_s1[47:32], w_s1[63:48]} : w_s1[63:32];

    w_s3 = w_s2;
    for (int l = 0; l < 4; l++) begin
      if (i_s[SHUF_BYTE_BASE + l]) begin
        w_s3[16*l +: 16] = {w_s2[16*l +: 8], w_s2[16*l+8 +: 8]};
      end
    end

    w_s4 = w_s3;
    for (int b = 0; b < 8; b++) begin
      if (i_s[SHUF_NIB_BASE + b]) begin
        w_s4[8*b +: 8] = {w_s3[8*b +: 4], w_s3[8*b+4 +: 4]};
      end
    end

    o_v = i_s[SHUF_LANE_MIX] ? {w_s4[31:16], w_s4[47:32], w_s4[63:48], w_s4[15:0]} : w_s4;
  end

endmodule

// File: rtl/krr_round_iter.sv
// Iterative 64-bit key-mixing engine: one shuffle round per clock, ROUNDS
// rounds per block, valid/ready on both sides.
module krr_round_iter
  import krr_pkg::*;
#(
  parameter int ROUNDS = 4,
  parameter int CNTW   = 4
) (
  input logic             clock,
  input logic             reset,
  input logic             abort,
  krr_round_iter_if.slave bus
);

  krr_state_e        r_state;
  logic [CNTW-1:0]   r_cnt;
  logic [63:0]       r_x;
  logic [63:0]       r_k;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [63:0]       r_out_data;
  logic              r_busy;

  logic [63:0]       w_rk;
  logic [63:0]       w_mix;
  logic [63:0]       w_round;
  logic              w_last;

  // Only the low two counter bits matter: the key rotates by 16 bits per round.
  assign w_rk   = krr_round_key(r_k, 2'(r_cnt));
  assign w_mix  = r_x ^ w_rk;
  assign w_last = (r_cnt == CNTW'(ROUNDS - 1));

  krr_shuf_net u_shuf (
    .i_v (w_mix),
    .i_s (w_rk[15:0]),
    .o_v (w_round)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = r_busy;

  // abort outranks any handshake in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_x         <= '0;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else if (abort) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_x        <= bus.in_data;
            r_k        <= bus.in_key;
            r_cnt      <= '0;
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          r_x   <= w_round;
          r_cnt <= r_cnt + CNTW'(1);
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_out_data  <= w_round;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
